ysyx_25060173_imem_responder: RTL and testbench
===============================================

# ysyx_25060173_imem_responder

Instruction-memory responder: the memory side of the core's instruction fetch interface. It accepts a fetch address from the core's PC logic, looks up a word in an internal instruction array after a configurable latency, and returns the 32-bit instruction to the core. It also provides a load port so the bench or loader can preload the program image. Misaligned or out-of-range fetches return `ebreak`, so a runaway PC halts simulation.

## Interface
Parameters:
- `DEPTH`, default 1024: number of 32-bit words in the array; must be a power of two.
- `BASE`, default 32'h80000000: byte address of word 0.
- `LATENCY`, default 1: cycles from request accept to response valid; must be 1 or greater.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `req_valid`, input, 1: the core presents a fetch address.
- `req_ready`, output, 1: the responder can accept a request.
- `req_addr`, input, 32: fetch byte address (PC).
- `resp_valid`, output, 1: the response is valid.
- `resp_ready`, input, 1: the core accepts the response.
- `resp_inst`, output, 32: the fetched instruction.
- `resp_err`, output, 1: the fetch was misaligned or out of range.
- `load_we`, input, 1: preload write enable.
- `load_addr`, input, log2(DEPTH): preload word index.
- `load_data`, input, 32: preload data.

## Operation
- States:
  - IDLE: `req_ready`=1. On `req_valid`&&`req_ready` (accept):
    - latch the error flag and the array word;
    - if `LATENCY`==1, go to RESP; otherwise load `cnt`=`LATENCY`-1 and go to WAIT.
  - WAIT: `req_ready`=0. Decrement `cnt` each cycle. When `cnt`==1, go to RESP.
  - RESP: `resp_valid`=1. Hold `resp_inst`/`resp_err` stable. On `resp_ready`, go to IDLE.
- Range check:
  - in range when `req_addr`>=`BASE` and `req_addr`<`BASE`+4*`DEPTH`; compute with 33-bit arithmetic so there is no wrap at 0xFFFFFFFC.
  - index = (`req_addr`-`BASE`)>>2.
- Error when `req_addr[1:0]`!=0 or the address is out of range:
  - `resp_err`=1 and `resp_inst`=32'h00100073 (ebreak);
  - the array is not read.
- Data is sampled at the accept edge. Loads after accept do not alter the pending response.
- A load to the same word in the accept cycle: the old data is returned (read-before-write). The new data is visible to the next fetch.
- `load_we` is honoured in every state, including during reset. Array contents are never cleared by reset.
- Only one request is outstanding; no pipelining. `req_ready` depends only on state; no combinational path from `resp_ready`.

## Timing
- Reset:
  - state=IDLE, `cnt`=0, `resp_valid`=0, `resp_inst`=0, `resp_err`=0;
  - `req_ready`=0 while `reset` is high, 1 in the first cycle after `reset` deasserts.
- Accept in cycle t gives `resp_valid`=1 from cycle t+`LATENCY`.
- Response handshake in cycle r gives `resp_valid`=0 and `req_ready`=1 in cycle r+1. The earliest next accept is r+1.
  - Peak throughput: one fetch per `LATENCY`+1 cycles.
- `resp_ready` high before `resp_valid` is ignored; it does not pre-acknowledge.
- Backpressure: with `resp_ready` low, RESP holds indefinitely with outputs stable; `req_valid` is ignored.
- Reset mid-WAIT or mid-RESP: the in-flight request is dropped, no response is produced, and the outputs return to reset values in the next cycle.
- `resp_inst` and `resp_err` are registered outputs. Outside RESP they hold their last value; the consumer must qualify them with `resp_valid`.

## Test plan
- **Basic fetch:** `LATENCY`=1; preload index 0=32'h00500093 (addi x1,x0,5); request 0x80000000 in cycle t.
  - Required: `resp_valid`=1 in t+1, `resp_inst`=32'h00500093, `resp_err`=0; `req_ready`=1 in the cycle after `resp_ready`.
- **Latency and backpressure:** `LATENCY`=3; request 0x80000004 (word 1 = 32'h00100073).
  - Required: `resp_valid` rises exactly at t+3.
  - Hold `resp_ready`=0 for 5 cycles: outputs stay stable and `req_valid` pulses are not accepted.
- **Error fetches:** request 0x80000002, then 0x7FFFFFFC, then 0x80001000 (`DEPTH`=1024), then 0xFFFFFFFC.
  - Required: each gives `resp_err`=1 and `resp_inst`=32'h00100073.
- **Load/fetch collision:** word 2=A; in the accept cycle of 0x80000008, `load_we` writes B to index 2.
  - Required: the response returns A; the next fetch returns B.
- **Reset in WAIT:** `LATENCY`=4; assert `reset` one cycle at t+2.
  - Required: no `resp_valid` ever for that request; `req_ready`=1 at t+4; a new fetch completes normally with the array intact.
- **Back-to-back fetches:** sequential PCs 0x80000000..0x8000003C with `resp_ready` tied high.
  - Required: 16 responses in order, one every `LATENCY`+1 cycles, each matching the preload.

Source files
------------

// File: rtl/ysyx_25060173_imem_responder.sv
// rtl/ysyx_25060173_imem_responder.sv - instruction-memory responder with preload port
// Single-outstanding fetch responder: accept, wait LATENCY cycles, hold response until taken.
module ysyx_25060173_imem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h80000000,
  parameter int unsigned LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_inst,
  output logic                     resp_err,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [32:0] BASE_X   = {1'b0, BASE};
  localparam logic [32:0] LIMIT_X  = BASE_X + 33'(4 * DEPTH);
  localparam logic [31:0] EBREAK   = 32'h00100073;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic [31:0]   mem [DEPTH];

  logic [32:0]   addr_x;
  logic          in_range;
  logic          fetch_err;
  logic [AW-1:0] index;
  logic          accept;

  // 33-bit compare so addresses near 0xFFFFFFFC cannot wrap into range.
  assign addr_x    = {1'b0, req_addr};
  assign in_range  = (addr_x >= BASE_X) && (addr_x < LIMIT_X);
  assign fetch_err = (req_addr[1:0] != 2'b00) || !in_range;
  assign index     = AW'((req_addr - BASE) >> 2);

  assign req_ready  = (state == IDLE) && !reset;
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            cnt_nxt   = CNT_INIT;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response is captured at accept; later loads cannot disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      resp_inst <= '0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        resp_err  <= fetch_err;
        resp_inst <= fetch_err ? EBREAK : mem[index];
      end
    end
  end

  // Preload port is independent of reset so images survive a core reset.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_ysyx_25060173_imem_responder.sv
// tb/tb_ysyx_25060173_imem_responder.sv - self-checking bench for the imem responder
// Three instances (LATENCY 1, 3, 4) checked against an array model of the instruction memory.
module tb_ysyx_25060173_imem_responder;

  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] ADDI   = 32'h00500093;
  localparam logic [31:0] WORD_A = 32'h00a00113;
  localparam logic [31:0] WORD_B = 32'h00b00193;
  localparam logic [31:0] LAST   = 32'hcafe0013;

  typedef struct {
    logic [31:0] addr;
    logic        err;
    logic [31:0] inst;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [31:0] req_addr   [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_inst  [3];
  logic        resp_err   [3];
  logic        load_we    [3];
  logic [9:0]  load_addr  [3];
  logic [31:0] load_data  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ysyx_25060173_imem_responder #(
      .DEPTH  (1024),
      .BASE   (32'h80000000),
      .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_addr  (req_addr[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_inst (resp_inst[g]),
      .resp_err  (resp_err[g]),
      .load_we   (load_we[g]),
      .load_addr (load_addr[g]),
      .load_data (load_data[g])
    );
  end

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          last_resp [3];
  logic [31:0] mdl [3][1024];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: the fetch rules stated as plain address arithmetic over the model array.
  function automatic logic [32:0] ref_fetch(input int k, input logic [31:0] a);
    longint unsigned la;
    logic [31:0]     off;
    la  = 64'(a);
    off = a - 32'h80000000;
    if (a[1:0] != 2'b00 || la < 64'h80000000 || la >= 64'h80000000 + 64'd4096)
      return {1'b1, EBREAK};
    return {1'b0, mdl[k][off[11:2]]};
  endfunction

  // Starts at the negedge of the accept cycle, ends at the negedge after the handshake.
  task automatic fetch(input int k, input logic [31:0] addr, input logic e_err,
                       input logic [31:0] e_inst, input int stall, input bit early,
                       input bit ld_en, input logic [9:0] ld_idx, input logic [31:0] ld_data);
    logic [31:0] d;
    chk("req_ready_idle", 32'(req_ready[k]), 1);
    req_valid[k]  = 1'b1;
    req_addr[k]   = addr;
    resp_ready[k] = early;
    if (ld_en) begin
      load_we[k]   = 1'b1;
      load_addr[k] = ld_idx;
      load_data[k] = ld_data;
      mdl[k][ld_idx] = ld_data;
    end
    @(negedge clk);
    req_valid[k] = 1'b0;
    load_we[k]   = 1'b0;
    for (int c = 1; c < lat(k); c++) begin
      chk("wait_valid", 32'(resp_valid[k]), 0);
      chk("wait_ready", 32'(req_ready[k]), 0);
      @(negedge clk);
    end
    chk("resp_valid", 32'(resp_valid[k]), 1);
    chk("resp_inst", resp_inst[k], e_inst);
    chk("resp_err", 32'(resp_err[k]), 32'(e_err));
    last_resp[k] = cyc;
    for (int s = 0; s < stall; s++) begin
      resp_ready[k] = 1'b0;
      req_valid[k]  = 1'b1;
      req_addr[k]   = $urandom;
      if (ld_en) begin
        d = $urandom;
        load_we[k]   = 1'b1;
        load_addr[k] = ld_idx;
        load_data[k] = d;
        mdl[k][ld_idx] = d;
      end
      @(negedge clk);
      req_valid[k] = 1'b0;
      load_we[k]   = 1'b0;
      chk("hold_valid", 32'(resp_valid[k]), 1);
      chk("hold_inst", resp_inst[k], e_inst);
      chk("hold_err", 32'(resp_err[k]), 32'(e_err));
      chk("hold_ready", 32'(req_ready[k]), 0);
    end
    resp_ready[k] = 1'b1;
    req_valid[k]  = 1'b0;
    @(negedge clk);
    resp_ready[k] = early;
    chk("after_hs_valid", 32'(resp_valid[k]), 0);
    chk("after_hs_ready", 32'(req_ready[k]), 1);
  endtask

  vec_t        vt [7];
  logic [32:0] e;
  logic [31:0] a;
  logic [31:0] off;
  logic [31:0] w;
  logic [9:0]  li;
  int          r;
  int          prev;

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid[k]  = 1'b0;
      req_addr[k]   = '0;
      resp_ready[k] = 1'b0;
      load_we[k]    = 1'b0;
      load_addr[k]  = '0;
      load_data[k]  = '0;
    end

    // Preload the whole image while reset is held.
    for (int i = 0; i < 1024; i++) begin
      w = (i == 0) ? ADDI : (i == 1) ? EBREAK : (i == 2) ? WORD_A : (i == 1023) ? LAST : $urandom;
      for (int k = 0; k < 3; k++) begin
        load_we[k]   = 1'b1;
        load_addr[k] = 10'(i);
        load_data[k] = w;
        mdl[k][i]    = w;
      end
      @(negedge clk);
      if (i == 3) begin
        for (int k = 0; k < 3; k++) begin
          chk("rst_req_ready", 32'(req_ready[k]), 0);
          chk("rst_resp_valid", 32'(resp_valid[k]), 0);
          chk("rst_resp_inst", resp_inst[k], 0);
          chk("rst_resp_err", 32'(resp_err[k]), 0);
        end
      end
    end
    for (int k = 0; k < 3; k++) load_we[k] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("post_rst_ready", 32'(req_ready[k]), 1);

    vt[0] = '{32'h80000000, 1'b0, ADDI};
    vt[1] = '{32'h80000004, 1'b0, EBREAK};
    vt[2] = '{32'h80000ffc, 1'b0, LAST};
    vt[3] = '{32'h80000002, 1'b1, EBREAK};
    vt[4] = '{32'h7ffffffc, 1'b1, EBREAK};
    vt[5] = '{32'h80001000, 1'b1, EBREAK};
    vt[6] = '{32'hfffffffc, 1'b1, EBREAK};
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 7; i++)
        fetch(k, vt[i].addr, vt[i].err, vt[i].inst, (k == 1 && i == 1) ? 5 : 0, 1'b0,
              1'b0, 10'd0, 32'd0);

    // Same-word load in the accept cycle: old word now, new word next time.
    fetch(0, 32'h80000008, 1'b0, WORD_A, 0, 1'b0, 1'b1, 10'd2, WORD_B);
    fetch(0, 32'h80000008, 1'b0, WORD_B, 0, 1'b0, 1'b0, 10'd0, 32'd0);

    // Reset while the LATENCY=4 instance is in WAIT.
    chk("rw_ready", 32'(req_ready[2]), 1);
    req_valid[2] = 1'b1;
    req_addr[2]  = 32'h80000000;
    @(negedge clk);
    req_valid[2] = 1'b0;
    chk("rw_t1_valid", 32'(resp_valid[2]), 0);
    @(negedge clk);
    chk("rw_t2_valid", 32'(resp_valid[2]), 0);
    reset         = 1'b1;
    resp_ready[2] = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rw_t3_valid", 32'(resp_valid[2]), 0);
    chk("rw_t3_inst", resp_inst[2], 0);
    chk("rw_t3_err", 32'(resp_err[2]), 0);
    @(negedge clk);
    chk("rw_t4_ready", 32'(req_ready[2]), 1);
    for (int c = 0; c < 6; c++) begin
      chk("rw_no_resp", 32'(resp_valid[2]), 0);
      @(negedge clk);
    end
    resp_ready[2] = 1'b0;
    fetch(2, 32'h80000000, 1'b0, ADDI, 0, 1'b0, 1'b0, 10'd0, 32'd0);

    // Randomized fetches, stalls, early ready and loads against the model.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 40; n++) begin
        r = $urandom_range(0, 9);
        if (r < 6)       a = 32'h80000000 + ($urandom_range(0, 1023) << 2);
        else if (r == 6) a = (32'h80000000 + $urandom_range(0, 4095)) | 32'h1;
        else if (r == 7) a = $urandom;
        else if (r == 8) a = 32'h80001000 + ($urandom_range(0, 255) << 2);
        else             a = 32'h7ffffffc - ($urandom_range(0, 255) << 2);
        off = a - 32'h80000000;
        li  = ($urandom_range(0, 1) == 1) ? off[11:2] : 10'($urandom_range(0, 1023));
        e   = ref_fetch(k, a);
        fetch(k, a, e[32], e[31:0], $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), li, $urandom);
      end
    end

    // Back-to-back sequential PCs with resp_ready held high.
    for (int k = 0; k < 3; k++) begin
      prev = 0;
      for (int i = 0; i < 16; i++) begin
        a = 32'h80000000 + 32'(i * 4);
        e = ref_fetch(k, a);
        fetch(k, a, e[32], e[31:0], 0, 1'b1, 1'b0, 10'd0, 32'd0);
        if (i > 0) chk("b2b_interval", 32'(last_resp[k] - prev), 32'(lat(k) + 1));
        prev = last_resp[k];
      end
      resp_ready[k] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
